complex_acc_stage: RTL and testbench

- Downstream stage of the complex number multiplier.
- Consumes the multiplier's result handshake (res_val / res_ready, result_re / result_im) and accumulates ACC_LEN consecutive complex products into one complex sum, i.e. a complex dot-product.
- Presents the sum on a valid/ready output handshake.
- A flush input emits a partial sum early.

---
 rtl/complex_acc_if.sv | 32 +++
 rtl/complex_acc_stage.sv | 159 +++++++++++++++
 tb/tb_complex_acc_stage.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/complex_acc_if.sv
// Handshake bundle for complex_acc_stage: product input side and accumulated-sum output side.
// The stage uses the slave view; a driver or testbench uses the master view.
interface complex_acc_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ACC_LEN    = 4,
  parameter int GUARD_BITS = 4
);
  localparam int ACC_WIDTH = 2*DATA_WIDTH + GUARD_BITS;
  localparam int CNT_WIDTH = $clog2(ACC_LEN+1);

  logic                    in_val;
  logic                    in_ready;
  logic [2*DATA_WIDTH-1:0] in_re;
  logic [2*DATA_WIDTH-1:0] in_im;
  logic                    flush;
  logic                    acc_val;
  logic                    acc_ready;
  logic [ACC_WIDTH-1:0]    acc_re;
  logic [ACC_WIDTH-1:0]    acc_im;
  logic [CNT_WIDTH-1:0]    acc_cnt;
  logic                    acc_sat;

  modport slave (
    input  in_val, in_re, in_im, flush, acc_ready,
    output in_ready, acc_val, acc_re, acc_im, acc_cnt, acc_sat
  );

  modport master (
    output in_val, in_re, in_im, flush, acc_ready,
    input  in_ready, acc_val, acc_re, acc_im, acc_cnt, acc_sat
  );
endinterface

// File: rtl/complex_acc_stage.sv
// Accumulates ACC_LEN complex products into one complex sum (dot product), with early flush.
// Optional macro COMPLEX_ACC_SAT_EN: saturating per-part additions and a sticky acc_sat flag.
module complex_acc_stage #(
  parameter int DATA_WIDTH = 8,
  parameter int ACC_LEN    = 4,
  parameter int GUARD_BITS = 4
) (
  input logic             clk,
  input logic             rstn,
  input logic             sw_rst,
  complex_acc_if.slave    bus
);
  localparam int ACC_WIDTH = 2*DATA_WIDTH + GUARD_BITS;
  localparam int CNT_WIDTH = $clog2(ACC_LEN+1);
  localparam logic [CNT_WIDTH-1:0] LAST_CNT = CNT_WIDTH'(ACC_LEN-1);

  typedef enum logic {ACCUM, OUTPUT} state_t;

  typedef struct packed {
    logic [ACC_WIDTH-1:0] sum;
    logic                 sat;
  } add_t;

  function automatic add_t acc_add(input logic [ACC_WIDTH-1:0] a, input logic [ACC_WIDTH-1:0] b);
    add_t r;
`ifdef COMPLEX_ACC_SAT_EN
    logic [ACC_WIDTH:0] wide;
    wide = {a[ACC_WIDTH-1], a} + {b[ACC_WIDTH-1], b};
    // Two sign bits disagree exactly when the signed sum left the ACC_WIDTH range.
    if (wide[ACC_WIDTH] != wide[ACC_WIDTH-1]) begin
      r.sum = wide[ACC_WIDTH] ? {1'b1, {(ACC_WIDTH-1){1'b0}}} : {1'b0, {(ACC_WIDTH-1){1'b1}}};
      r.sat = 1'b1;
    end else begin
      r.sum = wide[ACC_WIDTH-1:0];
      r.sat = 1'b0;
    end
`else
    r.sum = a + b;
    r.sat = 1'b0;
`endif
    return r;
  endfunction

  state_t               state_q,   state_d;
  logic [CNT_WIDTH-1:0] cnt_q,     cnt_d;
  logic [ACC_WIDTH-1:0] sum_re_q,  sum_re_d;
  logic [ACC_WIDTH-1:0] sum_im_q,  sum_im_d;
  logic                 sat_q,     sat_d;
  logic [ACC_WIDTH-1:0] out_re_q,  out_re_d;
  logic [ACC_WIDTH-1:0] out_im_q,  out_im_d;
  logic [CNT_WIDTH-1:0] out_cnt_q, out_cnt_d;
  logic                 out_sat_q, out_sat_d;

  logic [ACC_WIDTH-1:0] ext_re, ext_im;
  logic [ACC_WIDTH-1:0] new_re, new_im;
  logic [CNT_WIDTH-1:0] new_cnt;
  logic                 new_sat;
  logic                 xfer;
  add_t                 add_re, add_im;

  assign ext_re = ACC_WIDTH'($signed(bus.in_re));
  assign ext_im = ACC_WIDTH'($signed(bus.in_im));

  always_comb begin
    // NOTE: every always_comb target gets a default first so no path can infer a latch.
    state_d   = state_q;
    cnt_d     = cnt_q;
    sum_re_d  = sum_re_q;
    sum_im_d  = sum_im_q;
    sat_d     = sat_q;
    out_re_d  = out_re_q;
    out_im_d  = out_im_q;
    out_cnt_d = out_cnt_q;
    out_sat_d = out_sat_q;

    xfer    = bus.in_val && (state_q == ACCUM);
    add_re  = acc_add(sum_re_q, ext_re);
    add_im  = acc_add(sum_im_q, ext_im);
    new_re  = sum_re_q;
    new_im  = sum_im_q;
    new_cnt = cnt_q;
    new_sat = sat_q;
    if (xfer) begin
      new_re  = add_re.sum;
      new_im  = add_im.sum;
      new_cnt = cnt_q + 1'b1;
      new_sat = sat_q | add_re.sat | add_im.sat;
    end

    unique case (state_q)
      ACCUM: begin
        sum_re_d = new_re;
        sum_im_d = new_im;
        cnt_d    = new_cnt;
        sat_d    = new_sat;
        // A flush with nothing accumulated and no same-cycle product is ignored.
        if ((xfer && cnt_q == LAST_CNT) || (bus.flush && new_cnt != '0)) begin
          out_re_d  = new_re;
          out_im_d  = new_im;
          out_cnt_d = new_cnt;
          out_sat_d = new_sat;
          sum_re_d  = '0;
          sum_im_d  = '0;
          cnt_d     = '0;
          sat_d     = 1'b0;
          state_d   = OUTPUT;
        end
      end
      OUTPUT: begin
        if (bus.acc_ready) state_d = ACCUM;
      end
      default: state_d = ACCUM;
    endcase

    if (sw_rst) begin
      state_d   = ACCUM;
      cnt_d     = '0;
      sum_re_d  = '0;
      sum_im_d  = '0;
      sat_d     = 1'b0;
      out_re_d  = '0;
      out_im_d  = '0;
      out_cnt_d = '0;
      out_sat_d = 1'b0;
    end
  end

  // NOTE: state registers use non-blocking assignments and all of them take the async reset.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= ACCUM;
      cnt_q     <= '0;
      sum_re_q  <= '0;
      sum_im_q  <= '0;
      sat_q     <= 1'b0;
      out_re_q  <= '0;
      out_im_q  <= '0;
      out_cnt_q <= '0;
      out_sat_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      sum_re_q  <= sum_re_d;
      sum_im_q  <= sum_im_d;
      sat_q     <= sat_d;
      out_re_q  <= out_re_d;
      out_im_q  <= out_im_d;
      out_cnt_q <= out_cnt_d;
      out_sat_q <= out_sat_d;
    end
  end

  assign bus.in_ready = (state_q == ACCUM);
  assign bus.acc_val  = (state_q == OUTPUT);
  assign bus.acc_re   = out_re_q;
  assign bus.acc_im   = out_im_q;
  assign bus.acc_cnt  = out_cnt_q;
  assign bus.acc_sat  = out_sat_q;
endmodule

// File: tb/tb_complex_acc_stage.sv
// Scoreboard bench for complex_acc_stage: directed products, expected sums queued at issue,
// monitors pop and compare on every output handshake. A second instance uses GUARD_BITS=0.
module tb_complex_acc_stage;
  localparam int DW = 8;
  localparam int AL = 4;
  localparam int GB = 4;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic sw_rst = 1'b0;
  always #5 clk = ~clk;

  complex_acc_if #(.DATA_WIDTH(DW), .ACC_LEN(AL), .GUARD_BITS(GB)) bus ();
  complex_acc_if #(.DATA_WIDTH(DW), .ACC_LEN(AL), .GUARD_BITS(0))  bus_g0 ();

  complex_acc_stage #(.DATA_WIDTH(DW), .ACC_LEN(AL), .GUARD_BITS(GB)) dut (
    .clk(clk), .rstn(rstn), .sw_rst(sw_rst), .bus(bus)
  );
  complex_acc_stage #(.DATA_WIDTH(DW), .ACC_LEN(AL), .GUARD_BITS(0)) dut_g0 (
    .clk(clk), .rstn(rstn), .sw_rst(sw_rst), .bus(bus_g0)
  );

  typedef struct {
    logic [31:0] re;
    logic [31:0] im;
    logic [31:0] cnt;
    logic [31:0] sat;
  } exp_t;

  exp_t q_main[$];
  exp_t q_g0[$];
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s", name);
  endtask

  // Scoreboard monitors: a sum is consumed on the edge where acc_val & acc_ready.
  always @(negedge clk) begin
    if (rstn && bus.acc_val && bus.acc_ready) begin
      if (q_main.size() == 0) fail_now("main_unexpected_output");
      else begin
        exp_t e;
        e = q_main.pop_front();
        check("main_acc_re",  32'(bus.acc_re),  e.re);
        check("main_acc_im",  32'(bus.acc_im),  e.im);
        check("main_acc_cnt", 32'(bus.acc_cnt), e.cnt);
        check("main_acc_sat", 32'(bus.acc_sat), e.sat);
      end
    end
  end

  always @(negedge clk) begin
    if (rstn && bus_g0.acc_val && bus_g0.acc_ready) begin
      if (q_g0.size() == 0) fail_now("g0_unexpected_output");
      else begin
        exp_t e;
        e = q_g0.pop_front();
        check("g0_acc_re",  32'(bus_g0.acc_re),  e.re);
        check("g0_acc_im",  32'(bus_g0.acc_im),  e.im);
        check("g0_acc_cnt", 32'(bus_g0.acc_cnt), e.cnt);
        check("g0_acc_sat", 32'(bus_g0.acc_sat), e.sat);
      end
    end
  end

  function automatic void expect_main(input logic [31:0] re, im, cnt, sat);
    q_main.push_back('{re, im, cnt, sat});
  endfunction

  task automatic wait_ready();
    int n = 0;
    while (!bus.in_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (!bus.in_ready) fail_now("in_ready_timeout");
  endtask

  task automatic send(input logic [15:0] re, input logic [15:0] im, input logic fl);
    wait_ready();
    bus.in_val = 1'b1;
    bus.in_re  = re;
    bus.in_im  = im;
    bus.flush  = fl;
    @(posedge clk); #1;
    bus.in_val = 1'b0;
    bus.flush  = 1'b0;
  endtask

  task automatic flush_pulse();
    bus.flush = 1'b1;
    @(posedge clk); #1;
    bus.flush = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout");
    $fatal(1, "simulation time limit reached");
  end

  initial begin
    bus.in_val = 1'b0; bus.in_re = '0; bus.in_im = '0; bus.flush = 1'b0; bus.acc_ready = 1'b0;
    bus_g0.in_val = 1'b0; bus_g0.in_re = '0; bus_g0.in_im = '0; bus_g0.flush = 1'b0;
    bus_g0.acc_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rstn = 1'b1;
    @(posedge clk); #1;

    check("rst_in_ready", 32'(bus.in_ready), 1);
    check("rst_acc_val",  32'(bus.acc_val),  0);
    check("rst_acc_re",   32'(bus.acc_re),   0);
    check("rst_acc_im",   32'(bus.acc_im),   0);
    check("rst_acc_cnt",  32'(bus.acc_cnt),  0);
    check("rst_acc_sat",  32'(bus.acc_sat),  0);

    // Full sum held by a stalled consumer; in_val pulses must not be accepted meanwhile.
    expect_main(16, 20, 4, 0);
    send(16'd1, 16'd2, 1'b0);
    send(16'd3, 16'd4, 1'b0);
    send(16'd5, 16'd6, 1'b0);
    send(16'd7, 16'd8, 1'b0);
    check("full_acc_val",  32'(bus.acc_val),  1);
    check("full_in_ready", 32'(bus.in_ready), 0);
    check("full_acc_cnt",  32'(bus.acc_cnt),  4);
    bus.in_val = 1'b1; bus.in_re = 16'd99; bus.in_im = 16'd99;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("stall_acc_val",  32'(bus.acc_val),  1);
      check("stall_acc_re",   32'(bus.acc_re),   16);
      check("stall_acc_im",   32'(bus.acc_im),   20);
      check("stall_in_ready", 32'(bus.in_ready), 0);
    end
    bus.in_val = 1'b0;
    bus.acc_ready = 1'b1;
    @(posedge clk); #1;
    check("release_acc_val",  32'(bus.acc_val),  0);
    check("release_in_ready", 32'(bus.in_ready), 1);

    // Negative real parts sign-extend: 4 * -1 = 20'hFFFFC.
    expect_main(32'h000F_FFFC, 4, 4, 0);
    for (int i = 0; i < 4; i++) send(16'hFFFF, 16'h0001, 1'b0);

    // Flush of a partial sum, then a flush with nothing accumulated.
    expect_main(40, 60, 2, 0);
    send(16'd10, 16'd20, 1'b0);
    send(16'd30, 16'd40, 1'b0);
    flush_pulse();
    wait_ready();
    flush_pulse();
    check("empty_flush_acc_val",  32'(bus.acc_val),  0);
    check("empty_flush_in_ready", 32'(bus.in_ready), 1);

    // Flush together with a product: with count 0 and with count 2.
    expect_main(1, 1, 1, 0);
    send(16'd1, 16'd1, 1'b1);
    expect_main(12, 15, 3, 0);
    send(16'd2, 16'd3, 1'b0);
    send(16'd4, 16'd5, 1'b0);
    send(16'd6, 16'd7, 1'b1);

    // Software reset discards a partial sum.
    wait_ready();
    send(16'd5, 16'd5, 1'b0);
    send(16'd5, 16'd5, 1'b0);
    sw_rst = 1'b1;
    @(posedge clk); #1;
    sw_rst = 1'b0;
    check("swrst_in_ready", 32'(bus.in_ready), 1);
    check("swrst_acc_val",  32'(bus.acc_val),  0);
    expect_main(4, 4, 4, 0);
    for (int i = 0; i < 4; i++) send(16'd1, 16'd1, 1'b0);

    // Software reset discards a presented, unconsumed sum.
    wait_ready();
    bus.acc_ready = 1'b0;
    for (int i = 0; i < 4; i++) send(16'd9, 16'd9, 1'b0);
    check("pre_swrst_acc_val", 32'(bus.acc_val), 1);
    sw_rst = 1'b1;
    @(posedge clk); #1;
    sw_rst = 1'b0;
    check("swrst_out_acc_val",  32'(bus.acc_val),  0);
    check("swrst_out_acc_re",   32'(bus.acc_re),   0);
    check("swrst_out_in_ready", 32'(bus.in_ready), 1);
    bus.acc_ready = 1'b1;

    // No guard bits: 16'h7000 + 16'h7000 overflows the 16-bit accumulator.
`ifdef COMPLEX_ACC_SAT_EN
    q_g0.push_back('{32'h7FFF, 0, 2, 1});
`else
    q_g0.push_back('{32'hE000, 0, 2, 0});
`endif
    bus_g0.in_val = 1'b1; bus_g0.in_re = 16'h7000; bus_g0.in_im = 16'h0000;
    @(posedge clk); #1;
    @(posedge clk); #1;
    bus_g0.in_val = 1'b0;
    bus_g0.flush = 1'b1;
    @(posedge clk); #1;
    bus_g0.flush = 1'b0;

    repeat (5) @(posedge clk);
    #1;
    check("main_queue_drained", 32'(q_main.size()), 0);
    check("g0_queue_drained",   32'(q_g0.size()),   0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
